pool_window_scheduler: RTL

Sequences the 3x3 max-pooling multicycle unit over a full feature map held in a synchronous-read SRAM. For each window it fetches 9 pixels, presents them to the pooling unit with a one-cycle valid, waits for its result and writes that result to the output buffer. A start/busy/done handshake lets the layer controller launch one pass per feature map.

---
 rtl/pool_window_scheduler.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/pool_window_scheduler.sv
// Walks 3x3 windows over a feature map in SRAM, feeds each to the
// max-pool unit and writes each pooled result to the output buffer.
module pool_window_scheduler #(
  parameter int MAP_W  = 8,
  parameter int MAP_H  = 8,
  parameter int STRIDE = 3,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              pool_valid_in,
  output logic [7:0]        pool_d0,
  output logic [7:0]        pool_d1,
  output logic [7:0]        pool_d2,
  output logic [7:0]        pool_d3,
  output logic [7:0]        pool_d4,
  output logic [7:0]        pool_d5,
  output logic [7:0]        pool_d6,
  output logic [7:0]        pool_d7,
  output logic [7:0]        pool_d8,
  input  logic              pool_valid_out,
  input  logic [7:0]        pool_data_out,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data
);

  localparam int OUT_W = (MAP_W - 3) / STRIDE + 1;
  localparam int OUT_H = (MAP_H - 3) / STRIDE + 1;

  localparam logic [ADDR_W-1:0] LAST_X = ADDR_W'((OUT_W - 1) * STRIDE);
  localparam logic [ADDR_W-1:0] LAST_Y = ADDR_W'((OUT_H - 1) * STRIDE);
  localparam logic [ADDR_W-1:0] STEP   = ADDR_W'(STRIDE);
  localparam logic [ADDR_W-1:0] ROW_W  = ADDR_W'(MAP_W);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [3:0]        k_q, k_d;
  logic [1:0]        kx_q, kx_d;
  logic [1:0]        ky_q, ky_d;
  logic [ADDR_W-1:0] ox_q, ox_d;
  logic [ADDR_W-1:0] oy_q, oy_d;
  logic [ADDR_W-1:0] oidx_q, oidx_d;
  logic [7:0]        res_q, res_d;
  logic [7:0]        pix_q [9];
  logic [7:0]        pix_d [9];

  logic [ADDR_W-1:0] rd_row;
  logic [ADDR_W-1:0] rd_col;

  // Read address follows the in-window row/column counters
  always_comb begin
    rd_row  = oy_q + ADDR_W'(ky_q);
    rd_col  = ox_q + ADDR_W'(kx_q);
    rd_en   = (state_q == S_FETCH) && (k_q != 4'd9);
    rd_addr = rd_en ? (rd_row * ROW_W + rd_col) : '0;
  end

  assign busy          = (state_q == S_FETCH) || (state_q == S_ISSUE) ||
                         (state_q == S_WAIT)  || (state_q == S_WRITE);
  assign done          = (state_q == S_DONE);
  assign pool_valid_in = (state_q == S_ISSUE);
  assign wr_en         = (state_q == S_WRITE);
  assign wr_addr       = oidx_q;
  assign wr_data       = res_q;

  assign pool_d0 = pix_q[0];
  assign pool_d1 = pix_q[1];
  assign pool_d2 = pix_q[2];
  assign pool_d3 = pix_q[3];
  assign pool_d4 = pix_q[4];
  assign pool_d5 = pix_q[5];
  assign pool_d6 = pix_q[6];
  assign pool_d7 = pix_q[7];
  assign pool_d8 = pix_q[8];

  // Pass sequencing: fetch, issue, wait for result, write, advance
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    kx_d    = kx_q;
    ky_d    = ky_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    oidx_d  = oidx_q;
    res_d   = res_q;
    for (int i = 0; i < 9; i++) pix_d[i] = pix_q[i];

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          ox_d    = '0;
          oy_d    = '0;
          oidx_d  = '0;
          k_d     = '0;
          kx_d    = '0;
          ky_d    = '0;
        end
      end
      S_FETCH: begin
        // SRAM data lags the strobe by one cycle
        for (int i = 0; i < 9; i++)
          if (k_q == 4'(i + 1)) pix_d[i] = rd_data;
        if (k_q == 4'd9) begin
          state_d = S_ISSUE;
          k_d     = '0;
          kx_d    = '0;
          ky_d    = '0;
        end else begin
          k_d = k_q + 4'd1;
          if (kx_q == 2'd2) begin
            kx_d = '0;
            ky_d = ky_q + 2'd1;
          end else begin
            kx_d = kx_q + 2'd1;
          end
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (pool_valid_out) begin
          res_d   = pool_data_out;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        oidx_d = oidx_q + 1'b1;
        // Last column origin is the only one whose next step overruns
        if (ox_q == LAST_X) begin
          ox_d = '0;
          oy_d = oy_q + STEP;
        end else begin
          ox_d = ox_q + STEP;
        end
        if ((ox_q == LAST_X) && (oy_q == LAST_Y)) state_d = S_DONE;
        else                                      state_d = S_FETCH;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      kx_q    <= '0;
      ky_q    <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      oidx_q  <= '0;
      res_q   <= '0;
      for (int i = 0; i < 9; i++) pix_q[i] <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      kx_q    <= kx_d;
      ky_q    <= ky_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      oidx_q  <= oidx_d;
      res_q   <= res_d;
      for (int i = 0; i < 9; i++) pix_q[i] <= pix_d[i];
    end
  end

endmodule
